// File: rtl/launch_queue_pkg.sv
// Shared constants for the DS->IS launch queue.
//   DS_TO_IS_BUS_WD : width of one decoded-instruction bus entry
//   LQ_DEPTH        : default number of queue entries (power of two, >= 2)
package launch_queue_pkg;
    localparam int DS_TO_IS_BUS_WD = 32;
    localparam int LQ_DEPTH        = 4;
endpackage

// File: rtl/launch_queue_if.sv
// Handshake bundle between decode (push side), issue (pop side) and the
// launch queue.
//   master : the DS/IS pipeline side, drives push/pop/flush
//   slave  : the launch queue, drives allowin, line1/line2, count, error
interface launch_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    logic                       flush_i;
    logic                       push_valid_i;
    logic [WIDTH-1:0]           push_bus_i;
    logic                       allowin_o;
    logic                       pop_i;
    logic                       line1_valid_o;
    logic [WIDTH-1:0]           line1_bus_o;
    logic                       line2_valid_o;
    logic [WIDTH-1:0]           line2_bus_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       error_o;

    modport master (
        output flush_i, push_valid_i, push_bus_i, pop_i,
        input  allowin_o, line1_valid_o, line1_bus_o, line2_valid_o,
               line2_bus_o, count_o, error_o
    );

    modport slave (
        input  flush_i, push_valid_i, push_bus_i, pop_i,
        output allowin_o, line1_valid_o, line1_bus_o, line2_valid_o,
               line2_bus_o, count_o, error_o
    );
endinterface

// File: rtl/launch_queue_ram.sv
// DEPTH x WIDTH entry storage for the launch queue.
//   clk            : write clock
//   we/waddr/wdata : single synchronous write port
//   raddr0/rdata0  : asynchronous read port (head entry)
//   raddr1/rdata1  : asynchronous read port (head+1 entry)
// Storage is deliberately not reset; validity is tracked by the queue count.
module launch_queue_ram
    import launch_queue_pkg::*;
#(
    parameter int DEPTH = LQ_DEPTH,
    parameter int WIDTH = DS_TO_IS_BUS_WD
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(DEPTH)-1:0]     waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0]     raddr0,
    output logic [WIDTH-1:0]             rdata0,
    input  logic [$clog2(DEPTH)-1:0]     raddr1,
    output logic [WIDTH-1:0]             rdata1
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];
endmodule

// File: rtl/launch_queue.sv
// Instruction launch queue between decode (DS) and issue (IS).
// Buffers DS buses and shows the oldest (line1) and next-oldest (line2)
// entries to IS; IS pops one entry per launch. Flush empties the queue.
//   clk, reset : clock and synchronous active-high reset
//   lq         : slave side of launch_queue_if (push/pop/flush in,
//                allowin/line1/line2/count/error out)
module launch_queue
    import launch_queue_pkg::*;
#(
    parameter int DEPTH = LQ_DEPTH,
    parameter int WIDTH = DS_TO_IS_BUS_WD
) (
    input  logic             clk,
    input  logic             reset,
    launch_queue_if.slave    lq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          error_q, error_d;
    logic          allowin;
    logic          push;
    logic          pop;
    logic          line1_valid;

    // allowin comes from registered count only, so a full queue refuses a
    // push even when IS pops in the same cycle.
    assign allowin     = (count_q != CW'(DEPTH));
    assign line1_valid = (count_q != '0);
    assign push        = lq.push_valid_i & allowin & ~lq.flush_i;
    assign pop         = lq.pop_i & line1_valid & ~lq.flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        error_d  = lq.push_valid_i & ~allowin & ~lq.flush_i;
        if (lq.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    launch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (push),
        .waddr  (wr_ptr_q),
        .wdata  (lq.push_bus_i),
        .raddr0 (rd_ptr_q),
        .rdata0 (lq.line1_bus_o),
        .raddr1 (rd_ptr_q + PW'(1)),
        .rdata1 (lq.line2_bus_o)
    );

    assign lq.allowin_o     = allowin;
    assign lq.line1_valid_o = line1_valid;
    assign lq.line2_valid_o = (count_q >= CW'(2));
    assign lq.count_o       = count_q;
    assign lq.error_o       = error_q;
endmodule

// File: tb/tb_launch_queue.sv
module tb_launch_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    launch_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) lq ();

    launch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .lq    (lq)
    );

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] sb [$];
    logic             exp_err = 1'b0;
    logic             chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: away from the active edge, compare presented outputs with the
    // scoreboard contents.
    always @(negedge clk) begin
        if (chk_en) begin
            check("count", 32'(lq.count_o), 32'(sb.size()));
            check("line1_valid", 32'(lq.line1_valid_o), 32'(sb.size() >= 1));
            check("line2_valid", 32'(lq.line2_valid_o), 32'(sb.size() >= 2));
            check("error", 32'(lq.error_o), 32'(exp_err));
            if (sb.size() >= 1) check("line1_bus", lq.line1_bus_o, sb[0]);
            if (sb.size() >= 2) check("line2_bus", lq.line2_bus_o, sb[1]);
        end
    end

    // One clock: drive inputs, take the edge, then apply the hand-computed
    // expected effect to the scoreboard.
    task automatic step(input logic rst, input logic pv, input logic [WIDTH-1:0] bus,
                        input logic pop, input logic fl,
                        input logic ex_push, input logic ex_pop, input logic ex_err);
        reset           = rst;
        lq.push_valid_i = pv;
        lq.push_bus_i   = bus;
        lq.pop_i        = pop;
        lq.flush_i      = fl;
        @(posedge clk);
        if (rst || fl) sb.delete();
        else begin
            if (ex_pop)  void'(sb.pop_front());
            if (ex_push) sb.push_back(bus);
        end
        exp_err = ex_err;
        #1;
        reset           = 1'b0;
        lq.push_valid_i = 1'b0;
        lq.pop_i        = 1'b0;
        lq.flush_i      = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        lq.push_valid_i = 1'b0;
        lq.push_bus_i   = '0;
        lq.pop_i        = 1'b0;
        lq.flush_i      = 1'b0;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        check("reset_count", 32'(lq.count_o), 0);
        check("reset_allowin", 32'(lq.allowin_o), 1);

        // 1: three pushes, no pop
        push(32'hA000_000A);
        push(32'hB000_000B);
        push(32'hC000_000C);
        check("t1_count", 32'(lq.count_o), 3);
        check("t1_line1", lq.line1_bus_o, 32'hA000_000A);
        check("t1_line2", lq.line2_bus_o, 32'hB000_000B);
        check("t1_allowin", 32'(lq.allowin_o), 1);

        // 2: fill, then offer while popping: pop taken, push refused, error
        push(32'hD000_000D);
        check("t2_full_allowin", 32'(lq.allowin_o), 0);
        step(1'b0, 1'b1, 32'hEEEE_EEEE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t2_count", 32'(lq.count_o), 3);
        check("t2_error", 32'(lq.error_o), 1);
        check("t2_allowin", 32'(lq.allowin_o), 1);
        check("t2_line1", lq.line1_bus_o, 32'hB000_000B);
        idle();
        pop1(); pop1(); pop1();
        check("t2_drained", 32'(lq.count_o), 0);

        // 3: streaming push+pop across pointer wrap
        push(32'h0000_D000);
        for (int n = 1; n < 10; n++) begin
            step(1'b0, 1'b1, 32'h0000_D000 + 32'(n), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            check("t3_line1", lq.line1_bus_o, 32'h0000_D000 + 32'(n));
            check("t3_count", 32'(lq.count_o), 1);
        end
        pop1();

        // 4: flush beats concurrent push and pop
        push(32'h4000_0001);
        push(32'h4000_0002);
        push(32'h4000_0003);
        step(1'b0, 1'b1, 32'h4000_0004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_count", 32'(lq.count_o), 0);
        check("t4_l1v", 32'(lq.line1_valid_o), 0);
        check("t4_l2v", 32'(lq.line2_valid_o), 0);
        push(32'hE000_000E);
        check("t4_line1", lq.line1_bus_o, 32'hE000_000E);
        pop1();

        // 5: popping an empty queue does nothing
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("t5_count", 32'(lq.count_o), 0);
            check("t5_error", 32'(lq.error_o), 0);
        end
        push(32'hF000_000F);
        push(32'hF000_0010);
        check("t5_line1", lq.line1_bus_o, 32'hF000_000F);
        check("t5_line2", lq.line2_bus_o, 32'hF000_0010);

        // 6: reset while full with an offered push (error would be pending)
        push(32'h6000_0001);
        push(32'h6000_0002);
        check("t6_count_full", 32'(lq.count_o), 4);
        step(1'b1, 1'b1, 32'h6000_0003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_count", 32'(lq.count_o), 0);
        check("t6_error", 32'(lq.error_o), 0);
        check("t6_l1v", 32'(lq.line1_valid_o), 0);
        // reset wins over an asserted error_o too
        push(32'h6100_0001); push(32'h6100_0002);
        push(32'h6100_0003); push(32'h6100_0004);
        step(1'b0, 1'b1, 32'h6100_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6b_error", 32'(lq.error_o), 0);
        check("t6b_count", 32'(lq.count_o), 0);
        push(32'h7000_0007);
        check("t6_after_line1", lq.line1_bus_o, 32'h7000_0007);
        idle();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
